// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave arbiter for the AHB3-Lite multi-layer switch. The highest priority
// requester wins, ties are broken round-robin, and ownership moves only at safe points.
module ahb3lite_interconnect_slave_arbiter #(
    parameter int unsigned MASTERS = 3
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [MASTERS-1:0]            mst_req,
    input  logic [MASTERS*3-1:0]          mst_priority,
    input  logic [MASTERS-1:0]            mst_can_switch,
    input  logic                          slv_HREADY,
    output logic [MASTERS-1:0]            master_granted,
    output logic [((MASTERS > 1) ? $clog2(MASTERS) : 1)-1:0] granted_master,
    output logic                          grant_valid,
    output logic                          grant_switch
);

    localparam int unsigned MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int unsigned PRIO_BITS   = 3;

    logic [MASTER_BITS-1:0] rr_ptr;
    logic                   owner_can_switch_c;
    logic                   switch_en_c;
    logic                   any_req_c;
    logic [PRIO_BITS-1:0]   maxp_c;
    logic [MASTERS-1:0]     cand_c;
    logic                   win_found_c;
    logic [MASTER_BITS-1:0] winner_c;
    logic [MASTERS-1:0]     winner_onehot_c;

    // The owner's can_switch, selected without an out-of-range index when MASTERS is not a power of two
    always_comb begin
        owner_can_switch_c = 1'b0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if (granted_master == MASTER_BITS'(m)) begin
                owner_can_switch_c = mst_can_switch[m];
            end
        end
    end

    assign switch_en_c = slv_HREADY & (~grant_valid | owner_can_switch_c);
    assign any_req_c   = |mst_req;

    // Highest requested priority and the set of masters sitting at it
    always_comb begin
        maxp_c = '0;
        cand_c = '0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if (mst_req[m] && (mst_priority[m*PRIO_BITS +: PRIO_BITS] > maxp_c)) begin
                maxp_c = mst_priority[m*PRIO_BITS +: PRIO_BITS];
            end
        end
        for (int unsigned m = 0; m < MASTERS; m++) begin
            cand_c[m] = mst_req[m] && (mst_priority[m*PRIO_BITS +: PRIO_BITS] == maxp_c);
        end
    end

    // Round-robin scan starting just after the last winner
    always_comb begin
        win_found_c = 1'b0;
        winner_c    = '0;
        for (int unsigned k = 1; k <= MASTERS; k++) begin
            for (int unsigned m = 0; m < MASTERS; m++) begin
                if (!win_found_c && cand_c[m] &&
                    (m == ((32'(rr_ptr) + k) % MASTERS))) begin
                    win_found_c = 1'b1;
                    winner_c    = MASTER_BITS'(m);
                end
            end
        end
    end

    always_comb begin
        winner_onehot_c = '0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            winner_onehot_c[m] = (winner_c == MASTER_BITS'(m));
        end
    end

    // Grant state; nothing moves unless the slave is ready and the owner allows it
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            master_granted <= '0;
            granted_master <= '0;
            grant_valid    <= 1'b0;
            grant_switch   <= 1'b0;
            rr_ptr         <= MASTER_BITS'(MASTERS - 1);
        end else if (switch_en_c) begin
            if (any_req_c) begin
                master_granted <= winner_onehot_c;
                granted_master <= winner_c;
                grant_valid    <= 1'b1;
                grant_switch   <= (winner_onehot_c != master_granted);
                rr_ptr         <= winner_c;
            end else begin
                // Park: drop the grant but keep the data mux on the last owner
                master_granted <= '0;
                grant_valid    <= 1'b0;
                grant_switch   <= (master_granted != '0);
            end
        end else begin
            grant_switch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Directed bench for the slave arbiter: a cycle-by-cycle vector trace plus a
// hand-written asynchronous reset sequence.
module tb_ahb3lite_interconnect_slave_arbiter;

    localparam int unsigned MASTERS = 3;

    logic       HCLK;
    logic       HRESETn;
    logic [2:0] mst_req;
    logic [8:0] mst_priority;
    logic [2:0] mst_can_switch;
    logic       slv_HREADY;
    logic [2:0] master_granted;
    logic [1:0] granted_master;
    logic       grant_valid;
    logic       grant_switch;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(MASTERS)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .mst_req        (mst_req),
        .mst_priority   (mst_priority),
        .mst_can_switch (mst_can_switch),
        .slv_HREADY     (slv_HREADY),
        .master_granted (master_granted),
        .granted_master (granted_master),
        .grant_valid    (grant_valid),
        .grant_switch   (grant_switch)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [2:0] req;
        logic [8:0] pri;
        logic [2:0] cs;
        logic       hr;
        logic [2:0] exp_g;
        logic [1:0] exp_gm;
        logic       exp_v;
        logic       exp_sw;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic logic [8:0] pri3(input int p2, input int p1, input int p0);
        return {3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic add(input logic [2:0] req, input logic [8:0] pri, input logic [2:0] cs,
                       input logic hr, input logic [2:0] g, input logic [1:0] gm,
                       input logic v, input logic sw);
        vec_t t;
        t.req = req; t.pri = pri; t.cs = cs; t.hr = hr;
        t.exp_g = g; t.exp_gm = gm; t.exp_v = v; t.exp_sw = sw;
        vecs.push_back(t);
    endtask

    task automatic check_outs(input string name, input logic [2:0] g, input logic [1:0] gm,
                              input logic v, input logic sw);
        n_vec++;
        if (master_granted !== g || granted_master !== gm || grant_valid !== v ||
            grant_switch !== sw) begin
            n_bad++;
            $display("FAIL %s: got granted=%b idx=%0d valid=%b switch=%b, want granted=%b idx=%0d valid=%b switch=%b",
                     name, master_granted, granted_master, grant_valid, grant_switch, g, gm, v, sw);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [8:0] pri, input logic [2:0] cs,
                         input logic hr);
        mst_req = req; mst_priority = pri; mst_can_switch = cs; slv_HREADY = hr;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        HRESETn = 1'b0;
        drive(3'b000, 9'd0, 3'b000, 1'b1);

        // Single request from idle
        add(3'b000, pri3(0,0,0), 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0);
        add(3'b010, pri3(0,0,0), 3'b111, 1'b1, 3'b010, 2'd1, 1'b1, 1'b1);
        add(3'b010, pri3(0,0,0), 3'b111, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0);
        // Equal-priority tie between 0 and 2 alternates
        add(3'b101, pri3(3,0,3), 3'b111, 1'b1, 3'b100, 2'd2, 1'b1, 1'b1);
        add(3'b101, pri3(3,0,3), 3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1);
        add(3'b101, pri3(3,0,3), 3'b111, 1'b1, 3'b100, 2'd2, 1'b1, 1'b1);
        add(3'b101, pri3(3,0,3), 3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1);
        // Burst by master 0: higher priority master 1 waits for can_switch
        add(3'b001, pri3(0,0,3), 3'b000, 1'b1, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,3), 3'b000, 1'b1, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,3), 3'b110, 1'b1, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,3), 3'b001, 1'b1, 3'b010, 2'd1, 1'b1, 1'b1);
        // Slave stalls with owner ready to switch
        add(3'b011, pri3(0,7,7), 3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,7), 3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,7), 3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b011, pri3(0,7,7), 3'b010, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1);
        // Move to master 2, owner drops req while locked, then releases
        add(3'b100, pri3(1,0,0), 3'b001, 1'b1, 3'b100, 2'd2, 1'b1, 1'b1);
        add(3'b000, pri3(0,0,0), 3'b000, 1'b1, 3'b100, 2'd2, 1'b1, 1'b0);
        add(3'b000, pri3(0,0,0), 3'b100, 1'b1, 3'b000, 2'd2, 1'b0, 1'b1);
        add(3'b000, pri3(0,0,0), 3'b100, 1'b1, 3'b000, 2'd2, 1'b0, 1'b0);
        // Idle slave not ready: nothing granted yet
        add(3'b001, pri3(0,0,5), 3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0);
        add(3'b001, pri3(0,0,5), 3'b000, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1);

        repeat (2) @(posedge HCLK);
        #1 check_outs("reset_state", 3'b000, 2'd0, 1'b0, 1'b0);

        @(negedge HCLK);
        HRESETn = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].pri, vecs[i].cs, vecs[i].hr);
            @(posedge HCLK);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_gm,
                          vecs[i].exp_v, vecs[i].exp_sw);
            @(negedge HCLK);
        end

        // Asynchronous reset while master 2 owns the slave
        drive(3'b100, pri3(2,0,0), 3'b111, 1'b1);
        @(posedge HCLK);
        #1 check_outs("pre_reset_grant", 3'b100, 2'd2, 1'b1, 1'b1);
        #2 HRESETn = 1'b0;
        #1 check_outs("async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge HCLK);
        drive(3'b101, pri3(3,0,3), 3'b111, 1'b1);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1 check_outs("post_reset_tie", 3'b001, 2'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        @(posedge HCLK);
        #1 check_outs("post_reset_rr", 3'b100, 2'd2, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
